// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-ported instruction/data SRAM between the
//            IF-stage fetch and the MEM-stage load/store. Data accesses win
//            over fetches, but a streak counter stops a stream of data
//            accesses from starving a waiting fetch forever. A taken branch
//            (if_abort) discards a fetch that is pending or in flight.
// Ports    : clk, rst           - clock, asynchronous active-high reset
//            im_req/im_addr     - fetch request (held until im_valid/if_abort)
//            if_abort           - taken branch: drop the current fetch
//            im_rdata/im_valid  - fetched word + one-cycle completion pulse
//            dm_req/dm_we/dm_addr/dm_wdata/dm_wstrb - load/store request
//            dm_rdata/dm_valid  - load data + one-cycle completion pulse
//            stall_if/stall_mem - per-stage stall requests
//            mem_*              - shared SRAM command / response
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int MAX_DM_STREAK = 4
) (
    input  logic                clk,
    input  logic                rst,
    // fetch port
    input  logic                im_req,
    input  logic [ADDR_W-1:0]   im_addr,
    input  logic                if_abort,
    output logic [DATA_W-1:0]   im_rdata,
    output logic                im_valid,
    // data port
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W/8-1:0] dm_wstrb,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                dm_valid,
    // pipeline stalls
    output logic                stall_if,
    output logic                stall_mem,
    // shared SRAM
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_ready,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam logic [3:0] c_STREAK_MAX = 4'(MAX_DM_STREAK);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DM_BUSY = 2'd1,
        ST_IM_BUSY = 2'd2
    } state_t;

    state_t                r_state,      w_state_nxt;
    logic [3:0]            r_streak,     w_streak_nxt;
    logic                  r_abort_pend, w_abort_pend_nxt;
    logic                  r_cmd_we,     w_cmd_we_nxt;
    logic [ADDR_W-1:0]     r_cmd_addr,   w_cmd_addr_nxt;
    logic [DATA_W-1:0]     r_cmd_wdata,  w_cmd_wdata_nxt;
    logic [DATA_W/8-1:0]   r_cmd_wstrb,  w_cmd_wstrb_nxt;
    logic [DATA_W-1:0]     r_im_rdata,   w_im_rdata_nxt;
    logic [DATA_W-1:0]     r_dm_rdata,   w_dm_rdata_nxt;
    logic                  r_im_valid,   w_im_valid_nxt;
    logic                  r_dm_valid,   w_dm_valid_nxt;

    // A requester whose valid is high this cycle is still holding req from
    // the transaction that just completed; masking it prevents a re-grant.
    logic w_dm_elig;
    logic w_im_elig;
    logic w_streak_full;
    logic w_grant_dm;
    logic w_grant_im;

    assign w_dm_elig     = dm_req & ~r_dm_valid;
    assign w_im_elig     = im_req & ~r_im_valid & ~if_abort;
    assign w_streak_full = (r_streak == c_STREAK_MAX);
    assign w_grant_dm    = w_dm_elig & (~w_im_elig | ~w_streak_full);
    assign w_grant_im    = w_im_elig & ~w_grant_dm;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_streak     <= 4'd0;
            r_abort_pend <= 1'b0;
            r_cmd_we     <= 1'b0;
            r_cmd_addr   <= '0;
            r_cmd_wdata  <= '0;
            r_cmd_wstrb  <= '0;
            r_im_rdata   <= '0;
            r_dm_rdata   <= '0;
            r_im_valid   <= 1'b0;
            r_dm_valid   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_streak     <= w_streak_nxt;
            r_abort_pend <= w_abort_pend_nxt;
            r_cmd_we     <= w_cmd_we_nxt;
            r_cmd_addr   <= w_cmd_addr_nxt;
            r_cmd_wdata  <= w_cmd_wdata_nxt;
            r_cmd_wstrb  <= w_cmd_wstrb_nxt;
            r_im_rdata   <= w_im_rdata_nxt;
            r_dm_rdata   <= w_dm_rdata_nxt;
            r_im_valid   <= w_im_valid_nxt;
            r_dm_valid   <= w_dm_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_streak_nxt     = r_streak;
        w_abort_pend_nxt = r_abort_pend;
        w_cmd_we_nxt     = r_cmd_we;
        w_cmd_addr_nxt   = r_cmd_addr;
        w_cmd_wdata_nxt  = r_cmd_wdata;
        w_cmd_wstrb_nxt  = r_cmd_wstrb;
        w_im_rdata_nxt   = r_im_rdata;
        w_dm_rdata_nxt   = r_dm_rdata;
        w_im_valid_nxt   = 1'b0;
        w_dm_valid_nxt   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_abort_pend_nxt = 1'b0;
                if (w_grant_dm) begin
                    w_state_nxt     = ST_DM_BUSY;
                    w_cmd_we_nxt    = dm_we;
                    w_cmd_addr_nxt  = dm_addr;
                    w_cmd_wdata_nxt = dm_wdata;
                    w_cmd_wstrb_nxt = dm_wstrb;
                    // Counts only grants made while a fetch is asking,
                    // including one currently masked by if_abort.
                    if (!im_req) begin
                        w_streak_nxt = 4'd0;
                    end else if (!w_streak_full) begin
                        w_streak_nxt = r_streak + 4'd1;
                    end
                end else if (w_grant_im) begin
                    w_state_nxt     = ST_IM_BUSY;
                    w_cmd_we_nxt    = 1'b0;
                    w_cmd_addr_nxt  = im_addr;
                    w_cmd_wdata_nxt = '0;
                    w_cmd_wstrb_nxt = '0;
                    w_streak_nxt    = 4'd0;
                end
            end
            ST_DM_BUSY: begin
                if (mem_ready) begin
                    w_state_nxt    = ST_IDLE;
                    w_dm_rdata_nxt = mem_rdata;
                    w_dm_valid_nxt = 1'b1;
                end
            end
            ST_IM_BUSY: begin
                if (if_abort) begin
                    w_abort_pend_nxt = 1'b1;
                end
                if (mem_ready) begin
                    // The SRAM access still finishes; only the result is
                    // suppressed if a branch was taken at any point.
                    w_state_nxt      = ST_IDLE;
                    w_abort_pend_nxt = 1'b0;
                    w_im_rdata_nxt   = mem_rdata;
                    w_im_valid_nxt   = ~(r_abort_pend | if_abort);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // mem_req is a pure decode of the state register so an asynchronous
    // reset drops it immediately.
    assign mem_req   = (r_state != ST_IDLE);
    assign mem_we    = r_cmd_we;
    assign mem_addr  = r_cmd_addr;
    assign mem_wdata = r_cmd_wdata;
    assign mem_wstrb = r_cmd_wstrb;

    assign im_rdata  = r_im_rdata;
    assign im_valid  = r_im_valid;
    assign dm_rdata  = r_dm_rdata;
    assign dm_valid  = r_dm_valid;

    assign stall_if  = ~rst & im_req & ~r_im_valid & ~if_abort;
    assign stall_mem = ~rst & dm_req & ~r_dm_valid;

endmodule
`default_nettype wire
